// File: rtl/seq_multiplier_pkg.sv
// Shared definitions for the sequential shift-add multiplier: default width,
// FSM state encoding and the ALU opcodes that read back the product halves.
package seq_multiplier_pkg;

    localparam int DEFAULT_WIDTH = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_SIGN = 2'd2
    } state_t;

    localparam logic [3:0] CODOP_MULH = 4'd13;
    localparam logic [3:0] CODOP_MULL = 4'd14;

endpackage

// File: rtl/seq_multiplier.sv
// Radix-2 sequential multiplier: signed operands are reduced to magnitudes on
// entry, WIDTH shift-add iterations run one per clock, and the sign is re-applied.
module seq_multiplier
    import seq_multiplier_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] mulH,
    output logic [WIDTH-1:0] mulL
);

    localparam int CW = $clog2(WIDTH) + 1;

    state_t             state_reg;
    logic [CW-1:0]      cnt_reg;
    logic [WIDTH-1:0]   mcand_reg;
    logic [WIDTH-1:0]   hi_reg;
    logic [WIDTH-1:0]   lo_reg;
    logic               neg_reg;
    logic               busy_reg;
    logic               done_reg;
    logic [WIDTH-1:0]   mulh_reg;
    logic [WIDTH-1:0]   mull_reg;

    logic [WIDTH-1:0]   mag_a_next;
    logic [WIDTH-1:0]   mag_b_next;
    logic [WIDTH:0]     sum_next;
    logic [2*WIDTH-1:0] prod_next;
    logic [2*WIDTH-1:0] result_next;

    always_comb begin
        mag_a_next  = (signed_op && op_a[WIDTH-1]) ? (~op_a + WIDTH'(1)) : op_a;
        mag_b_next  = (signed_op && op_b[WIDTH-1]) ? (~op_b + WIDTH'(1)) : op_b;
        // Extra adder bit keeps the carry, which is shifted into the high half.
        sum_next    = {1'b0, hi_reg} + (lo_reg[0] ? {1'b0, mcand_reg} : {(WIDTH+1){1'b0}});
        prod_next   = {hi_reg, lo_reg};
        result_next = neg_reg ? (~prod_next + (2*WIDTH)'(1)) : prod_next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            mcand_reg <= '0;
            hi_reg    <= '0;
            lo_reg    <= '0;
            neg_reg   <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            mulh_reg  <= '0;
            mull_reg  <= '0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        mcand_reg <= mag_a_next;
                        lo_reg    <= mag_b_next;
                        hi_reg    <= '0;
                        neg_reg   <= signed_op & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
                        cnt_reg   <= '0;
                        busy_reg  <= 1'b1;
                        state_reg <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    hi_reg <= sum_next[WIDTH:1];
                    lo_reg <= {sum_next[0], lo_reg[WIDTH-1:1]};
                    if (cnt_reg == CW'(WIDTH - 1)) begin
                        cnt_reg   <= '0;
                        state_reg <= ST_SIGN;
                    end else begin
                        cnt_reg <= cnt_reg + CW'(1);
                    end
                end
                ST_SIGN: begin
                    mulh_reg  <= result_next[2*WIDTH-1:WIDTH];
                    mull_reg  <= result_next[WIDTH-1:0];
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b1;
                    state_reg <= ST_IDLE;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign busy = busy_reg;
    assign done = done_reg;
    assign mulH = mulh_reg;
    assign mulL = mull_reg;

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed testbench for seq_multiplier with hand-computed products.
module tb_seq_multiplier;

    localparam int W   = 16;
    localparam int LAT = W + 1;

    logic         clk;
    logic         reset;
    logic         start;
    logic         signed_op;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         busy;
    logic         done;
    logic [W-1:0] mulH;
    logic [W-1:0] mulL;

    int checks   = 0;
    int failures = 0;

    seq_multiplier #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .signed_op (signed_op),
        .op_a      (op_a),
        .op_b      (op_b),
        .busy      (busy),
        .done      (done),
        .mulH      (mulH),
        .mulL      (mulL)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
        signed_op = s;
        op_a      = a;
        op_b      = b;
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    task automatic wait_done(output int lat, output bit ok);
        lat = 0;
        ok  = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (done === 1'b1) begin
                lat = i;
                ok  = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b1;
        signed_op = 1'b0;
        op_a = 16'h0003;
        op_b = 16'h0005;
        tick();
        tick();
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++;
        if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++;
        if (mulH !== 16'h0000 || mulL !== 16'h0000) begin
            failures++; $display("FAIL reset_product got=%h_%h exp=0000_0000", mulH, mulL);
        end
        start = 1'b0;
        reset = 1'b0;
        $display("test_reset: busy=%b done=%b mulH=%h mulL=%h", busy, done, mulH, mulL);
    endtask

    task automatic test_timing_3x5();
        bit busy_ok = 1'b1;
        issue(1'b0, 16'h0003, 16'h0005);
        for (int i = 1; i < LAT; i++) begin
            tick();
            if (busy !== 1'b1 || done !== 1'b0) busy_ok = 1'b0;
        end
        checks++;
        if (!busy_ok) begin failures++; $display("FAIL calc_busy got=not_held exp=busy1_done0"); end
        tick();
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            failures++; $display("FAIL done_edge got=done%b_busy%b exp=done1_busy0", done, busy);
        end
        checks++;
        if (mulH !== 16'h0000 || mulL !== 16'h000F) begin
            failures++; $display("FAIL prod_3x5 got=%h_%h exp=0000_000f", mulH, mulL);
        end
        tick();
        checks++;
        if (done !== 1'b0) begin failures++; $display("FAIL done_width got=%b exp=0", done); end
        $display("test_timing_3x5: mulH=%h mulL=%h", mulH, mulL);
    endtask

    typedef struct {
        logic         s;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] h;
        logic [W-1:0] l;
    } vec_t;

    task automatic test_products();
        vec_t vecs[9];
        int   lat;
        bit   ok;
        vecs[0] = '{1'b0, 16'hFFFF, 16'hFFFF, 16'hFFFE, 16'h0001};
        vecs[1] = '{1'b1, 16'h0007, 16'hFFFD, 16'hFFFF, 16'hFFEB};
        vecs[2] = '{1'b1, 16'h8000, 16'h8000, 16'h4000, 16'h0000};
        vecs[3] = '{1'b0, 16'h0000, 16'h1234, 16'h0000, 16'h0000};
        vecs[4] = '{1'b1, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h0001};
        vecs[5] = '{1'b1, 16'h8000, 16'h0001, 16'hFFFF, 16'h8000};
        vecs[6] = '{1'b0, 16'h8000, 16'h8000, 16'h4000, 16'h0000};
        vecs[7] = '{1'b1, 16'h0000, 16'hFFFD, 16'h0000, 16'h0000};
        vecs[8] = '{1'b0, 16'h1234, 16'h5678, 16'h0626, 16'h0060};
        foreach (vecs[i]) begin
            issue(vecs[i].s, vecs[i].a, vecs[i].b);
            wait_done(lat, ok);
            checks++;
            if (!ok || lat != LAT) begin
                failures++; $display("FAIL latency_%0d got=%0d exp=%0d", i, lat, LAT);
            end
            checks++;
            if (mulH !== vecs[i].h || mulL !== vecs[i].l) begin
                failures++;
                $display("FAIL product_%0d got=%h_%h exp=%h_%h", i, mulH, mulL, vecs[i].h, vecs[i].l);
            end
            $display("test_products[%0d]: s=%b %h*%h -> %h_%h lat=%0d",
                     i, vecs[i].s, vecs[i].a, vecs[i].b, mulH, mulL, lat);
            tick();
        end
    endtask

    task automatic test_ignore_start();
        int n_done = 0;
        int first  = 0;
        issue(1'b0, 16'h0003, 16'h0005);
        for (int i = 1; i <= 40; i++) begin
            if (i == 5) begin
                op_a  = 16'h0010;
                op_b  = 16'h0010;
                start = 1'b1;
            end else begin
                start = 1'b0;
                if (i > 5) begin
                    op_a = 16'hAAAA;
                    op_b = 16'h5555;
                end
            end
            tick();
            if (done === 1'b1) begin
                n_done++;
                if (first == 0) first = i;
            end
        end
        start = 1'b0;
        checks++;
        if (n_done != 1 || first != LAT) begin
            failures++; $display("FAIL ignore_start got=dones%0d_at%0d exp=dones1_at%0d", n_done, first, LAT);
        end
        checks++;
        if (mulH !== 16'h0000 || mulL !== 16'h000F) begin
            failures++; $display("FAIL ignore_result got=%h_%h exp=0000_000f", mulH, mulL);
        end
        $display("test_ignore_start: dones=%0d first=%0d mulL=%h", n_done, first, mulL);
    endtask

    task automatic test_reset_mid();
        bit quiet = 1'b1;
        int lat;
        bit ok;
        issue(1'b0, 16'h00FF, 16'h00FF);
        for (int i = 1; i < 8; i++) tick();
        reset = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        reset = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || mulH !== 16'h0000 || mulL !== 16'h0000) begin
            failures++;
            $display("FAIL reset_mid got=busy%b_done%b_%h_%h exp=busy0_done0_0000_0000", busy, done, mulH, mulL);
        end
        issue(1'b0, 16'h0002, 16'h0003);
        wait_done(lat, ok);
        checks++;
        if (!ok || lat != LAT) begin
            failures++; $display("FAIL reset_restart_lat got=%0d exp=%0d", lat, LAT);
        end
        checks++;
        if (mulH !== 16'h0000 || mulL !== 16'h0006) begin
            failures++; $display("FAIL reset_restart got=%h_%h exp=0000_0006", mulH, mulL);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            if (done !== 1'b0) quiet = 1'b0;
        end
        checks++;
        if (!quiet) begin failures++; $display("FAIL reset_extra_done got=pulse exp=none"); end
        $display("test_reset_mid: restart mulL=%h lat=%0d", mulL, lat);
    endtask

    task automatic test_back_to_back();
        int lat;
        bit ok;
        issue(1'b0, 16'h0100, 16'h0100);
        wait_done(lat, ok);
        checks++;
        if (mulH !== 16'h0001 || mulL !== 16'h0000) begin
            failures++; $display("FAIL b2b_first got=%h_%h exp=0001_0000", mulH, mulL);
        end
        issue(1'b1, 16'hFFFE, 16'h0009);
        wait_done(lat, ok);
        checks++;
        if (!ok || lat != LAT) begin
            failures++; $display("FAIL b2b_lat got=%0d exp=%0d", lat, LAT);
        end
        checks++;
        if (mulH !== 16'hFFFF || mulL !== 16'hFFEE) begin
            failures++; $display("FAIL b2b_second got=%h_%h exp=ffff_ffee", mulH, mulL);
        end
        $display("test_back_to_back: second=%h_%h lat=%0d", mulH, mulL, lat);
        tick();
    endtask

    task automatic test_held_start();
        int n_done   = 0;
        bit stable   = 1'b1;
        bit double_d = 1'b0;
        bit prev_d   = 1'b0;
        signed_op = 1'b0;
        op_a      = 16'h0011;
        op_b      = 16'h0011;
        start     = 1'b1;
        for (int i = 0; i <= 53; i++) begin
            tick();
            if (done === 1'b1) begin
                n_done++;
                if (prev_d) double_d = 1'b1;
            end
            if (n_done > 0 && (mulH !== 16'h0000 || mulL !== 16'h0121)) stable = 1'b0;
            prev_d = done;
        end
        start = 1'b0;
        checks++;
        if (n_done != 3) begin failures++; $display("FAIL held_count got=%0d exp=3", n_done); end
        checks++;
        if (!stable || double_d) begin
            failures++; $display("FAIL held_stable got=%h_%h exp=0000_0121", mulH, mulL);
        end
        $display("test_held_start: dones=%0d mulL=%h", n_done, mulL);
    endtask

    initial begin
        reset     = 1'b0;
        start     = 1'b0;
        signed_op = 1'b0;
        op_a      = '0;
        op_b      = '0;
        test_reset();
        test_timing_3x5();
        test_products();
        test_ignore_start();
        test_reset_mid();
        test_back_to_back();
        test_held_start();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
